renderizador_entidades: RTL and testbench

//  Downstream pixel stage of the entities block. Takes a per-frame snapshot of every

---
 rtl/renderizador_entidades_if.sv | 27 ++
 rtl/renderizador_entidades.sv | 238 +++++++++++++++++++++++
 tb/tb_renderizador_entidades.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/renderizador_entidades_if.sv
// Pixel-timing inputs and VGA DAC outputs of the entity renderer.
// master: VGA timing side (drives pixels, receives colour); slave: renderer.
interface renderizador_entidades_if;
   logic       pixel_en;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       hs_in;
   logic       vs_in;
   logic       frame_start;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;

   modport master (
      output pixel_en, pixel_x, pixel_y, video_on, hs_in, vs_in, frame_start,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
   );

   modport slave (
      input  pixel_en, pixel_x, pixel_y, video_on, hs_in, vs_in, frame_start,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
   );
endinterface

// File: rtl/renderizador_entidades.sv
// Entity renderer: per-frame snapshot of entity positions, 3-stage pixel classifier,
// priority colour mux and matching sync/blank delay toward the VGA DAC.
module renderizador_entidades #(
   parameter int unsigned NAVE_W    = 45,
   parameter int unsigned NAVE_H    = 20,
   parameter int unsigned INIM_W    = 40,
   parameter int unsigned INIM_H    = 30,
   parameter int unsigned HUD_X0    = 8,
   parameter int unsigned HUD_Y0    = 8,
   parameter int unsigned HUD_SZ    = 10,
   parameter int unsigned HUD_PASSO = 16
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   renderizador_entidades_if.slave vga,
   input  logic [9:0]              x_nave,
   input  logic [9:0]              y_nave,
   input  logic [9:0]              x_bola_aliada,
   input  logic [9:0]              y_bola_aliada,
   input  logic [9:0]              raio_bola_aliada,
   input  logic [49:0]             x_bola_inimiga,
   input  logic [49:0]             y_bola_inimiga,
   input  logic [9:0]              raio_bola_inimiga,
   input  logic [49:0]             inimigo_x,
   input  logic [49:0]             inimigo_y,
   input  logic [0:4]              inimigo_vivo_array,
   input  logic [1:0]              vidas,
   input  logic                    perdeu
);

   // Half-open interval test with the upper bound summed in 11 bits so it never wraps.
   function automatic logic in_box(input logic [10:0] p, input logic [10:0] lo,
                                   input logic [10:0] w);
      return (p >= lo) && (p < (lo + w));
   endfunction

   function automatic logic [10:0] mag(input logic [10:0] d);
      return d[10] ? (~d + 11'd1) : d;
   endfunction

   function automatic logic ball_in(input logic [10:0] dx, input logic [10:0] dy,
                                    input logic [9:0] r);
      logic [22:0] ax, ay, rr;
      ax = 23'(mag(dx));
      ay = 23'(mag(dy));
      rr = 23'(r);
      return (ax * ax + ay * ay) <= (rr * rr);
   endfunction

   // Snapshot
   logic        sn_ok;
   logic [9:0]  sn_x_nave, sn_y_nave, sn_x_bal, sn_y_bal, sn_r_bal, sn_r_bin;
   logic [49:0] sn_x_bin, sn_y_bin, sn_ix, sn_iy;
   logic [0:4]  sn_vivo;
   logic [1:0]  sn_vidas;
   logic        sn_perdeu;

   // Capture every entity input once per frame so a frame never mixes two game states.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sn_ok     <= 1'b0;
         sn_x_nave <= '0;
         sn_y_nave <= '0;
         sn_x_bal  <= '0;
         sn_y_bal  <= '0;
         sn_r_bal  <= '0;
         sn_r_bin  <= '0;
         sn_x_bin  <= '0;
         sn_y_bin  <= '0;
         sn_ix     <= '0;
         sn_iy     <= '0;
         sn_vivo   <= '0;
         sn_vidas  <= '0;
         sn_perdeu <= 1'b0;
      end else if (vga.frame_start) begin
         sn_ok     <= 1'b1;
         sn_x_nave <= x_nave;
         sn_y_nave <= y_nave;
         sn_x_bal  <= x_bola_aliada;
         sn_y_bal  <= y_bola_aliada;
         sn_r_bal  <= raio_bola_aliada;
         sn_r_bin  <= raio_bola_inimiga;
         sn_x_bin  <= x_bola_inimiga;
         sn_y_bin  <= y_bola_inimiga;
         sn_ix     <= inimigo_x;
         sn_iy     <= inimigo_y;
         sn_vivo   <= inimigo_vivo_array;
         sn_vidas  <= vidas;
         sn_perdeu <= perdeu;
      end
   end

   // S1: ball offsets (index 0 = allied ball, 1..5 = enemy balls) and box hits
   logic [10:0] px, py;
   logic [10:0] dx_c [0:5];
   logic [10:0] dy_c [0:5];
   logic        ship_c, enemy_c;

   assign px = {1'b0, vga.pixel_x};
   assign py = {1'b0, vga.pixel_y};

   // Signed offsets to every ball centre, ship box and alive-enemy boxes.
   always_comb begin
      dx_c[0] = px - {1'b0, sn_x_bal};
      dy_c[0] = py - {1'b0, sn_y_bal};
      for (int i = 0; i < 5; i++) begin
         dx_c[i+1] = px - {1'b0, sn_x_bin[10*i +: 10]};
         dy_c[i+1] = py - {1'b0, sn_y_bin[10*i +: 10]};
      end
      ship_c = sn_ok && in_box(px, {1'b0, sn_x_nave}, 11'(NAVE_W))
                     && in_box(py, {1'b0, sn_y_nave}, 11'(NAVE_H));
      enemy_c = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (sn_ok && sn_vivo[i] && in_box(px, {1'b0, sn_ix[10*i +: 10]}, 11'(INIM_W))
                               && in_box(py, {1'b0, sn_iy[10*i +: 10]}, 11'(INIM_H))) begin
            enemy_c = 1'b1;
         end
      end
   end

   logic [10:0] s1_dx [0:5];
   logic [10:0] s1_dy [0:5];
   logic        s1_ok, s1_ship, s1_enemy, s1_perdeu;
   logic [9:0]  s1_x, s1_y, s1_r_al, s1_r_in;
   logic [1:0]  s1_vidas;
   logic [2:0]  vid_d, hs_d, vs_d;

   // S1 register plus the first tap of the sync/blank delay line.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) begin
            s1_dx[i] <= '0;
            s1_dy[i] <= '0;
         end
         s1_ok     <= 1'b0;
         s1_ship   <= 1'b0;
         s1_enemy  <= 1'b0;
         s1_perdeu <= 1'b0;
         s1_x      <= '0;
         s1_y      <= '0;
         s1_r_al   <= '0;
         s1_r_in   <= '0;
         s1_vidas  <= '0;
         vid_d     <= '0;
         hs_d      <= '1;
         vs_d      <= '1;
      end else if (vga.pixel_en) begin
         for (int i = 0; i < 6; i++) begin
            s1_dx[i] <= dx_c[i];
            s1_dy[i] <= dy_c[i];
         end
         s1_ok     <= sn_ok;
         s1_ship   <= ship_c;
         s1_enemy  <= enemy_c;
         s1_perdeu <= sn_ok && sn_perdeu;
         s1_x      <= vga.pixel_x;
         s1_y      <= vga.pixel_y;
         s1_r_al   <= sn_r_bal;
         s1_r_in   <= sn_r_bin;
         s1_vidas  <= sn_ok ? sn_vidas : 2'd0;
         vid_d     <= {vid_d[1:0], vga.video_on};
         hs_d      <= {hs_d[1:0], vga.hs_in};
         vs_d      <= {vs_d[1:0], vga.vs_in};
      end
   end

   // S2: circle hits and HUD life squares
   logic [5:0] ball_c;
   logic       life_c;

   // Circle test per ball and life-square test for every life still held.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         ball_c[i] = s1_ok && ball_in(s1_dx[i], s1_dy[i], (i == 0) ? s1_r_al : s1_r_in);
      end
      life_c = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
         if ((k < 32'(s1_vidas))
             && in_box({1'b0, s1_x}, 11'(HUD_X0 + k * HUD_PASSO), 11'(HUD_SZ))
             && in_box({1'b0, s1_y}, 11'(HUD_Y0), 11'(HUD_SZ))) begin
            life_c = 1'b1;
         end
      end
   end

   logic s2_ally, s2_eball, s2_ship, s2_enemy, s2_life, s2_perdeu;

   // S2 register: one flag per colour class.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         s2_ally   <= 1'b0;
         s2_eball  <= 1'b0;
         s2_ship   <= 1'b0;
         s2_enemy  <= 1'b0;
         s2_life   <= 1'b0;
         s2_perdeu <= 1'b0;
      end else if (vga.pixel_en) begin
         s2_ally   <= ball_c[0];
         s2_eball  <= |ball_c[5:1];
         s2_ship   <= s1_ship;
         s2_enemy  <= s1_enemy;
         s2_life   <= life_c;
         s2_perdeu <= s1_perdeu;
      end
   end

   // S3: priority mux
   logic [23:0] rgb_c, rgb;

   // Highest-priority class wins; blanking (taken in step with S3) forces black.
   always_comb begin
      rgb_c = 24'h000000;
      if (s2_perdeu)     rgb_c = 24'hFF0000;
      else if (s2_ally)  rgb_c = 24'hFFFFFF;
      else if (s2_eball) rgb_c = 24'hFF8000;
      else if (s2_ship)  rgb_c = 24'h00FFFF;
      else if (s2_enemy) rgb_c = 24'h00FF00;
      else if (s2_life)  rgb_c = 24'hFF00FF;
      if (!vid_d[1]) rgb_c = 24'h000000;
   end

   // S3 colour register.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         rgb <= '0;
      end else if (vga.pixel_en) begin
         rgb <= rgb_c;
      end
   end

   assign vga.VGA_R       = rgb[23:16];
   assign vga.VGA_G       = rgb[15:8];
   assign vga.VGA_B       = rgb[7:0];
   assign vga.VGA_HS      = hs_d[2];
   assign vga.VGA_VS      = vs_d[2];
   assign vga.VGA_BLANK_N = vid_d[2];

endmodule

// File: tb/tb_renderizador_entidades.sv
// Scoreboard bench for renderizador_entidades: stimulus pushes the hand-computed
// {RGB, HS, VS, BLANK_N} for each pixel strobe; a monitor pops and compares 3 strobes later.
module tb_renderizador_entidades;

   localparam logic [23:0] BLK  = 24'h000000;
   localparam logic [23:0] TEAL = 24'h00FFFF;
   localparam logic [23:0] WHT  = 24'hFFFFFF;
   localparam logic [23:0] ORG  = 24'hFF8000;
   localparam logic [23:0] GRN  = 24'h00FF00;
   localparam logic [23:0] MAG  = 24'hFF00FF;
   localparam logic [23:0] RED  = 24'hFF0000;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [9:0]  x_nave, y_nave, x_bal, y_bal, r_bal, r_bin;
   logic [49:0] x_bin, y_bin, ix, iy;
   logic [0:4]  vivo;
   logic [1:0]  vidas;
   logic        perdeu;

   renderizador_entidades_if bus ();

   renderizador_entidades dut (
      .CLOCK_50           (CLOCK_50),
      .reset              (reset),
      .vga                (bus),
      .x_nave             (x_nave),
      .y_nave             (y_nave),
      .x_bola_aliada      (x_bal),
      .y_bola_aliada      (y_bal),
      .raio_bola_aliada   (r_bal),
      .x_bola_inimiga     (x_bin),
      .y_bola_inimiga     (y_bin),
      .raio_bola_inimiga  (r_bin),
      .inimigo_x          (ix),
      .inimigo_y          (iy),
      .inimigo_vivo_array (vivo),
      .vidas              (vidas),
      .perdeu             (perdeu)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      string       nm;
      logic [26:0] v;
      bit          chk;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_strobe = 0;

   task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [26:0] outs();
      return {bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N};
   endfunction

   // One pixel strobe; expected output is queued for the monitor.
   task automatic pix(input string nm, input int x, input int y, input logic vid,
                      input logic hs, input logic vs, input logic [23:0] rgb,
                      input bit chk, input logic fs);
      exp_t e;
      @(negedge CLOCK_50);
      bus.pixel_x     = 10'(x);
      bus.pixel_y     = 10'(y);
      bus.video_on    = vid;
      bus.hs_in       = hs;
      bus.vs_in       = vs;
      bus.frame_start = fs;
      bus.pixel_en    = 1'b1;
      e.nm  = nm;
      e.v   = {rgb, hs, vs, vid};
      e.chk = chk;
      sb.push_back(e);
      @(negedge CLOCK_50);
      bus.pixel_en    = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic px(input string nm, input int x, input int y, input logic [23:0] rgb);
      pix(nm, x, y, 1'b1, 1'b1, 1'b1, rgb, 1'b1, 1'b0);
   endtask

   task automatic snap();
      @(negedge CLOCK_50);
      bus.frame_start = 1'b1;
      @(negedge CLOCK_50);
      bus.frame_start = 1'b0;
   endtask

   // Monitor: output after strobe n belongs to the pixel issued at strobe n-2.
   always begin
      @(posedge CLOCK_50);
      if (bus.pixel_en && !reset) begin
         n_strobe++;
         #1;
         if (n_strobe >= 3) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL scoreboard_underflow: got empty queue required an entry");
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.chk) check(mon_e.nm, outs(), mon_e.v);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.pixel_en = 1'b0; bus.pixel_x = '0; bus.pixel_y = '0;
      bus.video_on = 1'b0; bus.hs_in = 1'b1; bus.vs_in = 1'b1; bus.frame_start = 1'b0;
      x_nave = 10'd300; y_nave = 10'd440;
      x_bal = 10'd1000; y_bal = 10'd1000; r_bal = 10'd0;
      x_bin = {5{10'd1000}}; y_bin = {5{10'd1000}}; r_bin = 10'd0;
      ix = '0; iy = '0; vivo = '0; vidas = 2'd0; perdeu = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      #1 check("reset_state", outs(), {24'h0, 1'b1, 1'b1, 1'b0});
      @(negedge CLOCK_50);
      reset = 1'b0;

      // No snapshot yet: everything black, syncs delayed.
      for (int i = 0; i < 24; i++) begin
         pix("sweep_no_snap", i * 37, i * 19, (i % 5) != 0, (i % 3) == 0, (i % 7) < 3,
             BLK, 1'b1, 1'b0);
      end
      px("no_snap_ship", 300, 440, BLK);

      // Ship box edges.
      snap();
      px("ship_tl", 300, 440, TEAL);
      px("ship_right_in", 344, 440, TEAL);
      px("ship_right_excl", 345, 440, BLK);
      px("ship_left_out", 299, 440, BLK);
      px("ship_bottom_in", 300, 459, TEAL);
      px("ship_bottom_excl", 300, 460, BLK);
      pix("ship_blank", 300, 440, 1'b0, 1'b0, 1'b1, BLK, 1'b1, 1'b0);

      // Balls and priority.
      x_bal = 10'd322; y_bal = 10'd430; r_bal = 10'd5;
      x_bin[9:0] = 10'd310; y_bin[9:0] = 10'd445;
      x_bin[19:10] = 10'd322; y_bin[19:10] = 10'd430; r_bin = 10'd2;
      snap();
      px("ally_edge", 325, 434, WHT);
      px("ally_outside", 326, 434, BLK);
      px("ally_over_eball", 322, 430, WHT);
      px("eball_over_ship", 310, 445, ORG);
      px("eball_edge", 312, 445, ORG);
      px("eball_out_ship", 313, 445, TEAL);

      // Enemies, alive bit, snapshot hold, radius 0.
      x_bin = {5{10'd1000}}; y_bin = {5{10'd1000}};
      x_bal = 10'd500; y_bal = 10'd200; r_bal = 10'd0;
      ix[29:20] = 10'd200; iy[29:20] = 10'd100;
      ix[9:0] = 10'd300; iy[9:0] = 10'd440;
      vivo = '0; vivo[0] = 1'b1;
      snap();
      px("radius0_centre", 500, 200, WHT);
      px("radius0_next", 501, 200, BLK);
      px("enemy_dead", 210, 110, BLK);
      px("ship_over_enemy", 305, 445, TEAL);
      vivo[2] = 1'b1;
      px("enemy_no_snap", 210, 110, BLK);
      snap();
      px("enemy_alive", 210, 110, GRN);
      px("enemy_right_in", 239, 100, GRN);
      px("enemy_right_excl", 240, 100, BLK);
      px("enemy_bottom_in", 200, 129, GRN);
      px("enemy_bottom_excl", 200, 130, BLK);

      // Mid-frame change is ignored; a frame_start on a strobe applies from the next one.
      x_nave = 10'd600; vivo[0] = 1'b0;
      px("hold_old_ship", 300, 440, TEAL);
      px("hold_new_ship", 600, 440, BLK);
      pix("fs_with_strobe", 300, 440, 1'b1, 1'b1, 1'b1, TEAL, 1'b1, 1'b1);
      px("after_fs_old", 300, 440, BLK);
      px("after_fs_new", 600, 440, TEAL);

      // HUD lives, then game over.
      vidas = 2'd2;
      snap();
      px("life0", 8, 8, MAG);
      px("life0_corner", 17, 17, MAG);
      px("life0_right_excl", 18, 8, BLK);
      px("life1", 24, 8, MAG);
      px("life2_absent", 40, 8, BLK);
      px("life0_below", 8, 18, BLK);
      vidas = 2'd3;
      snap();
      px("life2", 40, 8, MAG);
      px("life2_right", 49, 8, MAG);
      px("life2_excl", 50, 8, BLK);
      perdeu = 1'b1;
      snap();
      px("over_origin", 0, 0, RED);
      px("over_ship", 600, 440, RED);
      px("over_life", 40, 8, RED);
      pix("over_blank", 100, 100, 1'b0, 1'b0, 1'b0, BLK, 1'b1, 1'b0);

      // Flush the pipeline.
      pix("flush", 0, 0, 1'b0, 1'b1, 1'b1, BLK, 1'b0, 1'b0);
      pix("flush", 0, 0, 1'b0, 1'b1, 1'b1, BLK, 1'b0, 1'b0);
      repeat (4) @(negedge CLOCK_50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
